// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
//   - buf_state_e : result-buffer occupancy state
//   - rr_pick     : round-robin search returning {found, idx}
package adder_sched_pkg;

  localparam int unsigned DEF_W       = 4;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned MAX_REQ     = 8;
  localparam int unsigned MAX_ID_W    = 3;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } buf_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid scanning ptr, ptr+1, ..., wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                       input logic [MAX_ID_W-1:0] ptr,
                                       input int unsigned         n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = (32'(ptr) + k) % n;
      if ((k < n) && !r.found && valid[MAX_ID_W'(j)]) begin
        r.found = 1'b1;
        r.idx   = MAX_ID_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational pick plus registered priority pointer.
//   clk, rst_n : clock, async active-low reset (pointer -> 0)
//   valid_i    : per-requester request
//   en_i       : grants allowed this cycle
//   grant_o    : one-hot grant (zero when none)
//   idx_o      : granted index, found_o : a grant is issued
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               found_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  rr_pick_t        pick;

  // Search and grant decode.
  always_comb begin
    pick    = rr_pick(MAX_REQ'(valid_i), MAX_ID_W'(ptr_q), NUM_REQ);
    found_o = en_i & pick.found;
    idx_o   = ID_W'(pick.idx);
    grant_o = '0;
    if (found_o) grant_o = NUM_REQ'(1) << idx_o;
  end

  // Pointer moves just past the winner so it has lowest priority next.
  always_comb begin
    ptr_d = ptr_q;
    if (found_o) begin
      if (idx_o == ID_W'(NUM_REQ - 1)) ptr_d = '0;
      else                             ptr_d = idx_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one external combinational adder among NUM_REQ requesters.
//   req_valid/req_a/req_b/req_ready : requester handshakes, packed operands
//   adder_a/adder_b/adder_sum       : connection to the shared adder
//   res_valid/res_ready             : one-entry result buffer handshake
//   res_sum/res_id/res_wrap         : buffered sum, producer index, carry-out
//   ops_count                       : accepted-operation counter (wraps)
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [W-1:0]         adder_a,
  output logic [W-1:0]         adder_b,
  input  logic [W-1:0]         adder_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W-1:0]         res_sum,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_wrap,
  output logic [CNT_W-1:0]     ops_count
);

  buf_state_e      state_q, state_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            can_accept_c;
  logic            accept_c;
  logic [ID_W-1:0] gnt_idx_c;

  // Free slot now, or one being popped this cycle; never grant in reset.
  assign can_accept_c = rst_n & ((state_q == S_EMPTY) |
                                 (res_ready & (state_q == S_FULL)));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (req_valid),
    .en_i    (can_accept_c),
    .grant_o (req_ready),
    .idx_o   (gnt_idx_c),
    .found_o (accept_c)
  );

  // Steer the granted requester's operands to the adder; zero when idle.
  always_comb begin
    adder_a = '0;
    adder_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept_c && (gnt_idx_c == ID_W'(i))) begin
        adder_a = req_a[i*W +: W];
        adder_b = req_b[i*W +: W];
      end
    end
  end

  // Buffer next state and result capture.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    if (accept_c) begin
      state_d = S_FULL;
      sum_d   = adder_sum;
      id_d    = gnt_idx_c;
      wrap_d  = (adder_sum < adder_a);
      cnt_d   = cnt_q + CNT_W'(1);
    end else if ((state_q == S_FULL) && res_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res_valid = (state_q == S_FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;
  assign res_wrap  = wrap_q;
  assign ops_count = cnt_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: directed scenarios followed by
// random traffic, compared against a transaction-level reference model.
module tb_adder_rr_scheduler;

  localparam int unsigned NR    = 4;
  localparam int unsigned W     = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a, req_b;
  logic [NR-1:0]   req_ready;
  logic [W-1:0]    adder_a, adder_b, adder_sum;
  logic            res_valid, res_ready;
  logic [W-1:0]    res_sum;
  logic [ID_W-1:0] res_id;
  logic            res_wrap;
  logic [CNT_W-1:0] ops_count;

  logic [W-1:0] op_a [NR];
  logic [W-1:0] op_b [NR];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_full;
  int m_sum, m_id, m_ptr, m_cnt;
  bit m_wrap;
  int last_g;

  always #5 clk = ~clk;

  assign adder_sum = adder_a + adder_b;

  adder_rr_scheduler #(
    .NUM_REQ (NR),
    .W       (W),
    .ID_W    (ID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_sum (adder_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .res_wrap  (res_wrap),
    .ops_count (ops_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_sum = 0; m_id = 0; m_wrap = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic pack();
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  endtask

  // One clock: check grant/adder inputs, clock, then check buffered result.
  task automatic step(input string tag);
    int g;
    int s;
    logic [NR-1:0] er;
    pack();
    #1;
    g = -1;
    if (!m_full || res_ready) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(er));
    chk({tag, ".adder_a"}, 32'(adder_a), (g >= 0) ? 32'(op_a[g]) : 32'd0);
    chk({tag, ".adder_b"}, 32'(adder_b), (g >= 0) ? 32'(op_b[g]) : 32'd0);
    last_g = g;
    @(posedge clk);
    if (g >= 0) begin
      s      = int'(op_a[g]) + int'(op_b[g]);
      m_full = 1;
      m_sum  = s % (1 << W);
      m_wrap = (s >= (1 << W));
      m_id   = g;
      m_ptr  = (g + 1) % NR;
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
    end else if (m_full && res_ready) begin
      m_full = 0;
    end
    #1;
    chk({tag, ".res_valid"}, 32'(res_valid), 32'(m_full));
    chk({tag, ".res_sum"},   32'(res_sum),   32'(m_sum));
    chk({tag, ".res_id"},    32'(res_id),    32'(m_id));
    chk({tag, ".res_wrap"},  32'(res_wrap),  32'(m_wrap));
    chk({tag, ".ops_count"}, 32'(ops_count), 32'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic [ID_W-1:0] held_id;

    rst_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; end
    pack();
    model_reset();
    last_g = -1;
    repeat (2) @(negedge clk);
    chk("reset.res_valid", 32'(res_valid), 32'd0);
    chk("reset.ops_count", 32'(ops_count), 32'd0);
    chk("reset.req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from requester 2: 3 + 4
    req_valid = 4'b0100; op_a[2] = 4'h3; op_b[2] = 4'h4;
    pack(); #1;
    chk("t1.grant", 32'(req_ready), 32'h4);
    step("t1");
    chk("t1.sum", 32'(res_sum), 32'h7);
    chk("t1.id", 32'(res_id), 32'd2);
    chk("t1.cnt", 32'(ops_count), 32'd1);
    req_valid = '0;
    step("t1.idle");

    // Carry-out boundaries
    req_valid = 4'b0010; op_a[1] = 4'hF; op_b[1] = 4'hF;
    step("t2a");
    chk("t2a.sum", 32'(res_sum), 32'hE);
    chk("t2a.wrap", 32'(res_wrap), 32'd1);
    op_a[1] = 4'h0; op_b[1] = 4'h0;
    step("t2b");
    chk("t2b.sum", 32'(res_sum), 32'h0);
    chk("t2b.wrap", 32'(res_wrap), 32'd0);
    op_a[1] = 4'hF; op_b[1] = 4'h1;
    step("t2c");
    chk("t2c.sum", 32'(res_sum), 32'h0);
    chk("t2c.wrap", 32'(res_wrap), 32'd1);

    // Backpressure: buffer full, consumer stalled
    req_valid = 4'b1001; op_a[0] = 4'h5; op_b[0] = 4'h6; op_a[3] = 4'h2; op_b[3] = 4'h9;
    res_ready = 1'b0;
    held_sum = res_sum; held_id = res_id;
    for (int c = 0; c < 3; c++) begin
      step("t4.stall");
      chk("t4.hold_sum", 32'(res_sum), 32'(held_sum));
      chk("t4.hold_id", 32'(res_id), 32'(held_id));
    end
    res_ready = 1'b1;
    step("t4.pop_accept");
    chk("t4.valid_kept", 32'(res_valid), 32'd1);

    // Asynchronous reset mid-stream while full with a pending grant
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) begin op_a[i] = 4'(i + 1); op_b[i] = 4'(2 * i); end
    step("t5.pre");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t5.valid_async", 32'(res_valid), 32'd0);
    chk("t5.cnt_async", 32'(ops_count), 32'd0);
    chk("t5.no_grant", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All valid from ptr=0: ids 0,1,2,3,0 one per cycle
    for (int c = 0; c < 5; c++) begin
      step("t3");
      chk("t3.id_order", 32'(res_id), 32'(c % NR));
    end
    chk("t3.cnt5", 32'(ops_count), 32'd5);

    // Counter wrap (CNT_W=4): accepts 6..15 then 16th returns to 0
    for (int c = 0; c < 10; c++) step("t6.fill");
    chk("t6.cnt15", 32'(ops_count), 32'd15);
    step("t6.wrap");
    chk("t6.cnt0", 32'(ops_count), 32'd0);

    // Random traffic honoring hold-until-accepted
    for (int c = 0; c < 400; c++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || last_g == i) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          op_a[i] = 4'($urandom);
          op_b[i] = 4'($urandom);
        end
      end
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
Round-robin scheduler that shares one combinational four_bit_adder among NUM_REQ requesters.
- Arbitrates among requesters with valid/ready handshakes.
- Drives the selected operands onto the shared adder and registers SUM into a one-entry result buffer.
- Tags each result with the requester ID and a wrap flag.
- Sits between requester logic and the single adder instance; the adder itself is instantiated outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, 4, operand/sum width; must match the adder
ID_W, 2, requester-ID width; must equal ceil(log2(NUM_REQ))
CNT_W, 16, width of the accepted-operation counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester operation request
req_a  in  NUM_REQ*W  operand A; requester i occupies bits [i*W +: W]
req_b  in  NUM_REQ*W  operand B; same packing as req_a
req_ready  out  NUM_REQ  one-hot grant; the operation is accepted when valid&ready
adder_a  out  W  to adder A
adder_b  out  W  to adder B
adder_sum  in  W  from adder SUM (combinational)
res_valid  out  1  result buffer full
res_ready  in  1  consumer accepts result
res_sum  out  W  registered sum
res_id  out  ID_W  index of the requester that produced res_sum
res_wrap  out  1  1 when the unsigned sum overflowed
ops_count  out  CNT_W  number of accepted operations, wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync deassert handled upstream): res_valid=0, res_sum=0, res_id=0, res_wrap=0, ops_count=0, rr pointer=0.
- Reset mid-operation: the buffered result is discarded and no grant is issued while rst_n=0.
- Buffer FSM, two states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- can_accept = (state==EMPTY) | (res_ready & state==FULL). A result popped and a new operation accepted in the same cycle gives zero bubbles.
- Arbitration (combinational):
  - If can_accept, grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
  - req_ready is one-hot for that i, or all-zero if there is no request or can_accept=0.
  - req_ready depends on req_valid; a requester must not make req_valid depend on req_ready.
- Datapath:
  - adder_a/adder_b = operands of the granted requester.
  - With no grant, adder_a/adder_b = 0.
- On an accept edge:
  - res_sum <= adder_sum; res_id <= i; res_wrap <= (adder_sum < adder_a), unsigned.
  - ptr <= (i+1) mod NUM_REQ.
  - ops_count <= ops_count+1, wrapping from 2^CNT_W-1 to 0.
  - state -> FULL.
- Pop without accept (FULL, res_ready=1, no grant): state -> EMPTY; res_sum/res_id/res_wrap hold their last values.
- FULL with res_ready=0: outputs are held stable and all req_ready=0 (backpressure).
- Latency: one edge from accept to res_valid=1. Sustained throughput is one op/cycle while res_ready=1.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- Arithmetic: modulo 2^W; the carry is visible only through res_wrap. Example: 4'hF + 4'h1 gives sum 0, wrap 1.
- Requesters must hold req_valid and operands until accepted. The block does not check this.

Decomposition:
- Package adder_sched_pkg holds:
  - state enum {S_EMPTY, S_FULL}
  - default widths (W=4, NUM_REQ=4)
  - function rr_pick(valid, ptr), returning grant index and found flag
- Optional sub-module rr_arbiter (combinational pick plus registered pointer).
- The adder instance stays in the parent/top level.

Test Plan:
1. Reset then a single request: req_valid=4'b0100, a=4'h3, b=4'h4, res_ready=1 -> req_ready=4'b0100; next edge res_valid=1, res_sum=4'h7, res_id=2, res_wrap=0, ops_count=1.
2. Wrap: a=4'hF, b=4'hF -> res_sum=4'hE, res_wrap=1. Then a=4'h0, b=4'h0 -> res_sum=0, res_wrap=0.
3. All four requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,...; res_id sequence 0,1,2,3,0; one result per cycle; ops_count=5 after 5 cycles.
4. Backpressure: buffer FULL with res_ready=0 for 3 cycles -> req_ready=0, res_sum/res_id stable. Then res_ready=1 -> pop and next grant in the same cycle, res_valid stays 1.
5. rst_n asserted low mid-stream with FULL and a pending grant -> res_valid=0 and ops_count=0 immediately (async). After release, the first grant goes to the lowest valid index from ptr=0.
6. ops_count wrap: preload via 65535 accepts (or CNT_W=4 build with 15 accepts) -> the next accept gives ops_count=0.
